// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// State encodings, stream framing constants and the word-address helper.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_LEN   = 3'd1,
        LD_DATA  = 3'd2,
        LD_FLUSH = 3'd3,
        LD_ERROR = 3'd4
    } ld_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

    // Byte address of word number idx relative to base.
    function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                   input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// MSB-first byte-to-word shifter with a 2-bit byte index.
// o_word presents the word completed by the byte currently being shifted in.
module byte_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_shift_en,
    input  logic        i_clear,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic [1:0]  o_byte_idx,
    output logic        o_last_byte
);

    logic [23:0] r_shift;
    logic [1:0]  r_idx;

    // Shift register and byte index; clear wins over a simultaneous shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 24'd0;
            r_idx   <= 2'd0;
        end else if (i_clear) begin
            r_shift <= 24'd0;
            r_idx   <= 2'd0;
        end else if (i_shift_en) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_shift <= r_shift;
            r_idx   <= r_idx;
        end
    end

    assign o_word      = {r_shift, i_byte};
    assign o_byte_idx  = r_idx;
    assign o_last_byte = i_shift_en && (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Stream-to-instruction-memory loader: parses a 16-bit word count and big-endian
// words, drives the CPU programming port and holds it in programming mode.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    parameter int          TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [31:0] o_prog_instruction,
    output logic [31:0] o_inst_addr,
    output logic        o_prog_en,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [15:0] o_words_loaded
);

    localparam int              TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
    localparam logic [16:0]     MAX_W    = 17'(MAX_WORDS);

    ld_state_e       r_state, w_state_nxt;
    logic [15:0]     r_len, w_len_nxt;
    logic [TO_W-1:0] r_to_cnt, w_to_nxt, w_to_inc;

    logic        r_rx_ready, r_prog_en, r_busy, r_done, r_error;
    logic [31:0] r_prog_instruction, w_instr_nxt;
    logic [31:0] r_inst_addr, w_addr_nxt;
    logic [15:0] r_words_loaded, w_words_nxt, w_words_inc;
    logic        w_done_nxt;

    logic        w_xfer, w_asm_shift, w_asm_clear, w_last_byte;
    logic [31:0] w_word;
    logic [1:0]  w_byte_idx;

    assign w_xfer      = i_rx_valid && r_rx_ready;
    assign w_to_inc    = r_to_cnt + TO_W'(1);
    assign w_words_inc = r_words_loaded + 16'd1;

    byte_assembler u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_shift_en  (w_asm_shift),
        .i_clear     (w_asm_clear),
        .i_byte      (i_rx_data),
        .o_word      (w_word),
        .o_byte_idx  (w_byte_idx),
        .o_last_byte (w_last_byte)
    );

    // State, length and idle-timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= LD_IDLE;
            r_len    <= 16'd0;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_len    <= w_len_nxt;
            r_to_cnt <= w_to_nxt;
        end
    end

    // Next-state, counter and commit decode.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_to_nxt    = r_to_cnt;
        w_instr_nxt = r_prog_instruction;
        w_addr_nxt  = r_inst_addr;
        w_words_nxt = r_words_loaded;
        w_done_nxt  = 1'b0;
        w_asm_shift = 1'b0;
        w_asm_clear = 1'b0;
        case (r_state)
            LD_IDLE, LD_ERROR: begin
                if (i_start) begin
                    w_state_nxt = LD_LEN;
                    w_words_nxt = 16'd0;
                    w_addr_nxt  = BASE_ADDR;
                    w_instr_nxt = 32'd0;
                    w_to_nxt    = '0;
                    w_asm_clear = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            LD_LEN: begin
                if (w_xfer) begin
                    w_asm_shift = 1'b1;
                    w_to_nxt    = '0;
                    if (w_byte_idx == 2'(HDR_BYTES - 1)) begin
                        // Reset the index so the first data byte lands in bits 31:24.
                        w_asm_clear = 1'b1;
                        w_len_nxt   = w_word[15:0];
                        if (w_word[15:0] == 16'd0) begin
                            w_state_nxt = LD_IDLE;
                            w_done_nxt  = 1'b1;
                        end else if ({1'b0, w_word[15:0]} > MAX_W) begin
                            w_state_nxt = LD_ERROR;
                        end else begin
                            w_state_nxt = LD_DATA;
                        end
                    end else begin
                        w_state_nxt = LD_LEN;
                    end
                end else if (w_to_inc == TO_LIMIT) begin
                    w_state_nxt = LD_ERROR;
                    w_to_nxt    = '0;
                end else begin
                    w_to_nxt = w_to_inc;
                end
            end
            LD_DATA: begin
                if (w_xfer) begin
                    w_asm_shift = 1'b1;
                    w_to_nxt    = '0;
                    if (w_last_byte) begin
                        w_instr_nxt = w_word;
                        w_addr_nxt  = word_byte_addr(BASE_ADDR, r_words_loaded);
                        w_words_nxt = w_words_inc;
                        if (w_words_inc == r_len) begin
                            w_state_nxt = LD_FLUSH;
                        end else begin
                            w_state_nxt = LD_DATA;
                        end
                    end else begin
                        w_state_nxt = LD_DATA;
                    end
                end else if (w_to_inc == TO_LIMIT) begin
                    w_state_nxt = LD_ERROR;
                    w_to_nxt    = '0;
                end else begin
                    w_to_nxt = w_to_inc;
                end
            end
            LD_FLUSH: begin
                w_state_nxt = LD_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = LD_IDLE;
            end
        endcase
    end

    // Output registers follow the state being entered so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ready         <= 1'b0;
            r_prog_en          <= 1'b0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_error            <= 1'b0;
            r_prog_instruction <= 32'd0;
            r_inst_addr        <= BASE_ADDR;
            r_words_loaded     <= 16'd0;
        end else begin
            r_rx_ready         <= (w_state_nxt == LD_LEN) || (w_state_nxt == LD_DATA);
            r_prog_en          <= (w_state_nxt == LD_LEN) || (w_state_nxt == LD_DATA) ||
                                  (w_state_nxt == LD_FLUSH);
            r_busy             <= (w_state_nxt == LD_LEN) || (w_state_nxt == LD_DATA) ||
                                  (w_state_nxt == LD_FLUSH);
            r_done             <= w_done_nxt;
            r_error            <= (w_state_nxt == LD_ERROR);
            r_prog_instruction <= w_instr_nxt;
            r_inst_addr        <= w_addr_nxt;
            r_words_loaded     <= w_words_nxt;
        end
    end

    assign o_rx_ready         = r_rx_ready;
    assign o_prog_en          = r_prog_en;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_error            = r_error;
    assign o_prog_instruction = r_prog_instruction;
    assign o_inst_addr        = r_inst_addr;
    assign o_words_loaded     = r_words_loaded;

endmodule
